// File: rtl/uart_pkg.sv
// Shared definitions for the UART keyboard: CPU register offsets, STATUS/DATA
// bit positions and the receiver state encoding.
package uart_pkg;

   // Register select values decoded from cpu_addr_in[3:2]
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;

   // DATA register layout
   localparam int unsigned DATA_VALID_BIT = 8;

   // STATUS register layout
   localparam int unsigned ST_COUNT_W   = 5;
   localparam int unsigned ST_FULL_BIT  = 5;
   localparam int unsigned ST_OVF_BIT   = 6;
   localparam int unsigned ST_FERR_BIT  = 7;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 bit-level receiver: synchronizes the line, finds the start bit, samples
// mid-bit, and reports each frame as a byte_valid or frame_error pulse.
// Ports:
//   clk_in, rst_in      clock, synchronous active-high reset
//   rx_in               asynchronous serial line (idle high)
//   rx_byte             last assembled byte (valid while byte_valid is high)
//   byte_valid          one-cycle pulse, good stop bit seen
//   frame_error         one-cycle pulse, stop bit sampled low
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rx_in,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_error
);

   localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT + 1);

   logic [1:0]       sync_q;
   logic             line;
   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             valid_d, ferr_d;

   assign line    = sync_q[1];
   assign rx_byte = shift_q;

   // State, counters and registered pulses
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync_q      <= 2'b11;
         state_q     <= RX_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         byte_valid  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], rx_in};
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         byte_valid  <= valid_d;
         frame_error <= ferr_d;
      end
   end

   // Next-state: start bit is re-checked at half-bit, then every full bit
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (!line) begin
               state_d = RX_START;
               cnt_d   = CNT_W'(HALF_BIT - 1);
            end
         end
         RX_START: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (!line) begin
               state_d = RX_DATA;
               cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
               bit_d   = '0;
            end else begin
               state_d = RX_IDLE;
            end
         end
         RX_DATA: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               shift_d = {line, shift_q[7:1]};
               cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
               if (bit_q == 3'd7) state_d = RX_STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         RX_STOP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (line) begin
               valid_d = 1'b1;
               state_d = RX_IDLE;
            end else begin
               ferr_d  = 1'b1;
               state_d = RX_WAIT_HIGH;
            end
         end
         RX_WAIT_HIGH: begin
            if (line) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_keyboard.sv
// Memory-mapped UART keyboard: received bytes queue in a FIFO readable via a
// DATA register; STATUS reports fill level and sticky error flags.
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   uart_rx_in            asynchronous serial line, 8N1, idle high
//   cpu_addr_in           byte address, only [3:2] decoded
//   cpu_data_in           write data
//   cpu_write_enable_in   byte enables, nonzero means write
//   cpu_data_out          read data, one cycle after the address
module uart_keyboard
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        uart_rx_in,
   input  logic [31:0] cpu_addr_in,
   input  logic [31:0] cpu_data_in,
   input  logic [3:0]  cpu_write_enable_in,
   output logic [31:0] cpu_data_out
);

   localparam int unsigned CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W        = PTR_W + 1;

   logic [7:0]       rx_byte;
   logic             rx_valid, rx_ferr;
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             ovf_q, ferr_q;
   logic             empty, full, wr_any, pop, push, ovf_set;
   logic             clr_ovf, clr_ferr;
   logic [1:0]       reg_sel;
   logic [7:0]       head;
   logic [31:0]      rd_data_c;
   logic             unused_bits;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .rx_in       (uart_rx_in),
      .rx_byte     (rx_byte),
      .byte_valid  (rx_valid),
      .frame_error (rx_ferr)
   );

   assign reg_sel  = cpu_addr_in[3:2];
   assign wr_any   = |cpu_write_enable_in;
   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop      = wr_any && (reg_sel == REG_DATA) && !empty;
   // A pop in the same cycle frees the slot the incoming byte needs
   assign push     = rx_valid && (!full || pop);
   assign ovf_set  = rx_valid && full && !pop;
   assign clr_ovf  = wr_any && (reg_sel == REG_STATUS) && cpu_data_in[ST_OVF_BIT];
   assign clr_ferr = wr_any && (reg_sel == REG_STATUS) && cpu_data_in[ST_FERR_BIT];
   assign head     = empty ? 8'h00 : fifo_mem[rd_ptr_q];

   assign unused_bits = ^{cpu_addr_in[31:4], cpu_addr_in[1:0],
                          cpu_data_in[31:8], cpu_data_in[5:0]};

   // FIFO storage; pointers alone define validity, so no reset needed
   always_ff @(posedge clk_in) begin
      if (push) fifo_mem[wr_ptr_q] <= rx_byte;
   end

   // Pointers, count and sticky flags (set beats clear)
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         ovf_q  <= ovf_set || (ovf_q && !clr_ovf);
         ferr_q <= rx_ferr || (ferr_q && !clr_ferr);
      end
   end

   // Read mux for the address presented this cycle
   always_comb begin
      rd_data_c = '0;
      case (reg_sel)
         REG_DATA: begin
            rd_data_c[7:0]            = head;
            rd_data_c[DATA_VALID_BIT] = !empty;
         end
         REG_STATUS: begin
            rd_data_c[ST_COUNT_W-1:0] = ST_COUNT_W'(count_q);
            rd_data_c[ST_FULL_BIT]    = full;
            rd_data_c[ST_OVF_BIT]     = ovf_q;
            rd_data_c[ST_FERR_BIT]    = ferr_q;
         end
         default: rd_data_c = '0;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) cpu_data_out <= '0;
      else        cpu_data_out <= rd_data_c;
   end

endmodule
